// File: rtl/amem_wbpass_pkg.sv
// Shared constants for the A-memory front end: phase encoding and the
// address/data widths used by both this block and the A-memory RAM wrapper.
package amem_wbpass_pkg;

    localparam int AMEM_AW = 10;
    localparam int AMEM_DW = 32;

    // The shared A address bus alternates between operand read and write-back.
    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_e;

endpackage

// File: rtl/amem_wbpass.sv
// A-memory address multiplexer and write-back holder with pass-around.
// READ cycles present the source address to the RAM; WRITE cycles commit the
// pending L register. A read that lands between capture and commit of the
// same address returns the pending L value instead of the stale RAM word.
module amem_wbpass
    import amem_wbpass_pkg::*;
#(
    parameter int AW = AMEM_AW,
    parameter int DW = AMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ir_aadr,
    input  logic [AW-1:0] dest_aadr,
    input  logic          dest_a,
    input  logic [DW-1:0] ob,
    input  logic          advance,
    input  logic [DW-1:0] amem,
    output logic [AW-1:0] aadr,
    output logic          arp,
    output logic          awp,
    output logic [DW-1:0] l,
    output logic [DW-1:0] a,
    output logic          apass
);

    phase_e        phase;
    phase_e        phase_nxt;
    logic          wpend;
    logic [AW-1:0] wadr;
    logic          hit_q;
    logic [DW-1:0] pdata_q;
    logic          hit_d;
    logic          capture;

    // Full-width compare; a pending write only matches while it is live.
    assign hit_d   = wpend && (wadr == ir_aadr);
    // Completions are only honoured on WRITE-phase edges.
    assign capture = advance && dest_a;

    // Phase toggles every cycle; strobes and address depend only on state and ir_aadr.
    always_comb begin
        phase_nxt = (phase == PH_READ) ? PH_WRITE : PH_READ;
        aadr      = '0;
        arp       = 1'b0;
        awp       = 1'b0;
        if (!reset) begin
            if (phase == PH_READ) begin
                aadr = ir_aadr;
                arp  = 1'b1;
            end else begin
                aadr = wadr;
                awp  = wpend;
            end
        end
    end

    // Phase register; reset restarts the sequence on a READ cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_READ;
        end else begin
            phase <= phase_nxt;
        end
    end

    // READ edge: remember whether this read hit the pending write and snapshot L.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q   <= 1'b0;
            pdata_q <= '0;
        end else if (phase == PH_READ) begin
            hit_q   <= hit_d;
            pdata_q <= l;
        end
    end

    // WRITE edge: RAM data is now valid; substitute the snapshot on a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            a     <= '0;
            apass <= 1'b0;
        end else if (phase == PH_WRITE) begin
            a     <= hit_q ? pdata_q : amem;
            apass <= hit_q;
        end
    end

    // WRITE edge: latch a new write-back, or retire the one committed this cycle.
    // A capture coinciding with a commit keeps wpend set; the old pair is already
    // on the RAM port through awp, so nothing is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            wpend <= 1'b0;
            wadr  <= '0;
            l     <= '0;
        end else if (phase == PH_WRITE) begin
            if (capture) begin
                wadr  <= dest_aadr;
                l     <= ob;
                wpend <= 1'b1;
            end else if (wpend) begin
                wpend <= 1'b0;
            end
        end
    end

endmodule
